// File: rtl/mac_rx_buf_if.sv
// Bus bundle for mac_rx_buf: the MAC receive side (i_data/i_valid/i_busy),
// the consumer byte stream (o_data/o_valid/i_ready/o_last/o_len/o_frame_rdy)
// and status (o_full, o_drop_cnt), plus FSM state for debug/checkers.
//
// Stream handshake: a beat transfers on a rising clock edge where
// o_valid & i_ready are both high. Once o_valid is raised it stays high, and
// o_data/o_last stay stable, until that beat is accepted; i_ready may change
// freely and does not depend on o_valid.
interface mac_rx_buf_if #(
  parameter int LW = 11
);
  logic [7:0]    i_data;
  logic          i_valid;
  logic          i_busy;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic [LW-1:0] o_len;
  logic          o_frame_rdy;
  logic          o_full;
  logic [7:0]    o_drop_cnt;
  logic [1:0]    dbg_wstate;
  logic [1:0]    dbg_rstate;

  // Producer/consumer side (testbench or upstream/downstream logic)
  modport master (
    output i_data, i_valid, i_busy, i_ready,
    input  o_data, o_valid, o_last, o_len, o_frame_rdy, o_full, o_drop_cnt,
    input  dbg_wstate, dbg_rstate
  );

  // Buffer side
  modport slave (
    input  i_data, i_valid, i_busy, i_ready,
    output o_data, o_valid, o_last, o_len, o_frame_rdy, o_full, o_drop_cnt,
    output dbg_wstate, dbg_rstate
  );
endinterface

// File: rtl/mac_rx_buf.sv
// mac_rx_buf: frame buffer behind the RMII MAC receiver.
// Payload bytes are written into a byte RAM while i_busy is high; at the end
// of a frame good frames are committed (length pushed to a small queue),
// runt/oversize/overflow frames are discarded by rewinding the write pointer.
// Committed frames are replayed as a valid/ready byte stream.
// Optional feature macro: RX_BUF_FCS_STRIP_EN -- when defined the trailing
// 4 FCS bytes of each frame are removed at commit time.
module mac_rx_buf #(
  parameter int DEPTH   = 2048,
  parameter int MIN_LEN = 46,
  parameter int MAX_LEN = 1500,
  parameter int NFRAMES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mac_rx_buf_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int QW = $clog2(NFRAMES);

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_L   = LW'(MIN_LEN);
  localparam logic [QW:0]   LQ_CAP  = (QW + 1)'(NFRAMES);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FRAME = 2'd1, W_DROP = 2'd2} wstate_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_STREAM = 2'd2} rstate_e;

  // Storage (no reset: RAM contents are only read once committed)
  logic [7:0]    mem    [DEPTH];
  logic [LW-1:0] lq_mem [NFRAMES];
  logic [7:0]    rd_data_q;

  // State
  wstate_e       wstate_q, wstate_d;
  rstate_e       rstate_q, rstate_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wptr_c_q, wptr_c_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [QW:0]   lq_wr_q, lq_wr_d;
  logic [QW:0]   lq_rd_q, lq_rd_d;
  logic [LW-1:0] o_len_q, o_len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          o_valid_q, o_valid_d;
  logic          o_last_q, o_last_d;
  logic          frame_rdy_q, frame_rdy_d;

  // Combinational helpers
  logic          sof, eof;
  logic [PW-1:0] used;
  logic          ram_full, lq_full, lq_empty;
  logic          wr_ok, wr_ovf;
  logic [LW-1:0] len_inc;
  logic [PW-1:0] wptr_inc;
  logic [LW-1:0] commit_len;
  logic [PW-1:0] commit_wptr;
  logic          commit_ok;
  logic          mem_we, lq_push, lq_pop, rd_en, drop_evt, accept;
  logic [AW-1:0] rd_addr;

  // busy_q is the registered i_busy; frame edges come from comparing the two
  assign busy_d   = bus.i_busy;
  assign sof      = bus.i_busy & ~busy_q;
  assign eof      = ~bus.i_busy & busy_q;

  // Pointers carry one extra wrap bit so used==DEPTH is distinguishable from 0
  assign used     = wptr_q - rptr_q;
  assign ram_full = (used == DEPTH_P);
  assign lq_full  = ((lq_wr_q - lq_rd_q) == LQ_CAP);
  assign lq_empty = (lq_wr_q == lq_rd_q);

  // A byte arriving with eof is still written, so commit decisions use len_inc
  assign wr_ok    = (wstate_q == W_FRAME) & bus.i_valid & ~ram_full & (len_q < MAX_L);
  assign wr_ovf   = (wstate_q == W_FRAME) & bus.i_valid & ~wr_ok;
  assign len_inc  = len_q + LW'(wr_ok);
  assign wptr_inc = wptr_q + PW'(wr_ok);

`ifdef RX_BUF_FCS_STRIP_EN
  // Strip the 4 FCS bytes: shorter frames are runts, and the FCS RAM space
  // is handed back by committing (and continuing from) wptr-4.
  assign commit_len  = len_inc - LW'(4);
  assign commit_wptr = wptr_inc - PW'(4);
  assign commit_ok   = ~wr_ovf & (len_inc >= LW'(4)) & (commit_len >= MIN_L);
`else
  assign commit_len  = len_inc;
  assign commit_wptr = wptr_inc;
  assign commit_ok   = ~wr_ovf & (len_inc >= MIN_L);
`endif

  assign accept = o_valid_q & bus.i_ready;

  // State register for both FSMs and all datapath flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wstate_q    <= W_IDLE;
      rstate_q    <= R_IDLE;
      busy_q      <= 1'b0;
      wptr_q      <= '0;
      wptr_c_q    <= '0;
      rptr_q      <= '0;
      len_q       <= '0;
      drop_cnt_q  <= '0;
      lq_wr_q     <= '0;
      lq_rd_q     <= '0;
      o_len_q     <= '0;
      cnt_q       <= '0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      frame_rdy_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      busy_q      <= busy_d;
      wptr_q      <= wptr_d;
      wptr_c_q    <= wptr_c_d;
      rptr_q      <= rptr_d;
      len_q       <= len_d;
      drop_cnt_q  <= drop_cnt_d;
      lq_wr_q     <= lq_wr_d;
      lq_rd_q     <= lq_rd_d;
      o_len_q     <= o_len_d;
      cnt_q       <= cnt_d;
      o_valid_q   <= o_valid_d;
      o_last_q    <= o_last_d;
      frame_rdy_q <= frame_rdy_d;
    end
  end

  // Payload RAM, length queue and registered RAM read port
  always_ff @(posedge i_clk) begin
    if (mem_we)  mem[wptr_q[AW-1:0]]     <= bus.i_data;
    if (lq_push) lq_mem[lq_wr_q[QW-1:0]] <= commit_len;
    if (rd_en)   rd_data_q               <= mem[rd_addr];
  end

  // Write FSM next state
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (sof) wstate_d = lq_full ? W_DROP : W_FRAME;
      W_FRAME: begin
        if (eof)         wstate_d = W_IDLE;
        else if (wr_ovf) wstate_d = W_DROP;
      end
      W_DROP:  if (eof) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: RAM write, commit/rewind, drop counting
  always_comb begin
    len_d      = len_q;
    wptr_d     = wptr_q;
    wptr_c_d   = wptr_c_q;
    drop_cnt_d = drop_cnt_q;
    mem_we     = 1'b0;
    lq_push    = 1'b0;
    drop_evt   = 1'b0;
    case (wstate_q)
      W_IDLE: if (sof) len_d = '0;
      W_FRAME: begin
        mem_we = wr_ok;
        len_d  = len_inc;
        wptr_d = wptr_inc;
        if (eof) begin
          if (commit_ok) begin
            lq_push  = 1'b1;
            wptr_c_d = commit_wptr;
            wptr_d   = commit_wptr;
          end else begin
            wptr_d   = wptr_c_q;
            drop_evt = 1'b1;
          end
        end
      end
      W_DROP: begin
        if (eof) begin
          wptr_d   = wptr_c_q;
          drop_evt = 1'b1;
        end
      end
      default: ;
    endcase
    if (drop_evt && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Length-queue pointers; a push and a pop in the same cycle both take effect
  always_comb begin
    lq_wr_d = lq_wr_q + (QW + 1)'(lq_push);
    lq_rd_d = lq_rd_q + (QW + 1)'(lq_pop);
  end

  // Read FSM next state
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:   if (!lq_empty) rstate_d = R_LOAD;
      R_LOAD:   rstate_d = R_STREAM;
      R_STREAM: if (accept && o_last_q) rstate_d = R_IDLE;
      default:  rstate_d = R_IDLE;
    endcase
  end

  // Read FSM outputs: pop, RAM prefetch, beat/last tracking
  always_comb begin
    rptr_d      = rptr_q;
    o_len_d     = o_len_q;
    cnt_d       = cnt_q;
    o_valid_d   = o_valid_q;
    o_last_d    = o_last_q;
    frame_rdy_d = frame_rdy_q;
    lq_pop      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rptr_q[AW-1:0];
    case (rstate_q)
      R_IDLE: begin
        if (!lq_empty) begin
          lq_pop      = 1'b1;
          o_len_d     = lq_mem[lq_rd_q[QW-1:0]];
          cnt_d       = lq_mem[lq_rd_q[QW-1:0]];
          frame_rdy_d = 1'b1;
          rd_en       = 1'b1;
        end
      end
      R_LOAD: begin
        o_valid_d = 1'b1;
        o_last_d  = (cnt_q == LW'(1));
      end
      R_STREAM: begin
        if (accept) begin
          rptr_d = rptr_q + PW'(1);
          if (o_last_q) begin
            o_valid_d   = 1'b0;
            o_last_d    = 1'b0;
            frame_rdy_d = 1'b0;
          end else begin
            // cnt_q counts beats left including the one being accepted
            cnt_d    = cnt_q - LW'(1);
            o_last_d = (cnt_q == LW'(2));
            rd_en    = 1'b1;
            rd_addr  = rptr_q[AW-1:0] + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // rd_data_q has no reset, so o_data is forced to 0 whenever no beat is offered
  assign bus.o_data      = o_valid_q ? rd_data_q : 8'h00;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_last      = o_last_q;
  assign bus.o_len       = o_len_q;
  assign bus.o_frame_rdy = frame_rdy_q;
  assign bus.o_full      = lq_full | ram_full;
  assign bus.o_drop_cnt  = drop_cnt_q;
  assign bus.dbg_wstate  = wstate_q;
  assign bus.dbg_rstate  = rstate_q;

endmodule

// File: tb/tb_mac_rx_buf.sv
// Directed testbench for mac_rx_buf with a byte scoreboard.
// Each expected beat is queued as {len, last, data} when the frame is sent
// and checked against the stream when the consumer accepts it.
module tb_mac_rx_buf;
  localparam int MAX_LEN = 1500;
`ifdef RX_BUF_FCS_STRIP_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad   = 0;
  int          exp_drop = 0;
  logic [19:0] exp_q[$];
  logic [19:0] e;
  logic        stall_seen = 1'b0;
  logic [7:0]  held_data  = 8'h00;
  logic        held_last  = 1'b0;

  mac_rx_buf_if bus ();

  mac_rx_buf dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: stall stability and accepted beats, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_seen) begin
        chk("stall_valid", 32'(bus.o_valid), 32'd1);
        chk("stall_data",  32'(bus.o_data),  32'(held_data));
        chk("stall_last",  32'(bus.o_last),  32'(held_last));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data",      32'(bus.o_data),      32'(e[7:0]));
          chk("beat_last",      32'(bus.o_last),      32'(e[8]));
          chk("beat_len",       32'(bus.o_len),       32'(e[19:9]));
          chk("beat_frame_rdy", 32'(bus.o_frame_rdy), 32'd1);
        end
      end
      stall_seen = bus.o_valid && !bus.i_ready;
      held_data  = bus.o_data;
      held_last  = bus.o_last;
    end else begin
      stall_seen = 1'b0;
    end
  end

  // Send n payload bytes base, base+1, ... (plus FCS bytes when stripping).
  // tail_eof puts the final byte in the same cycle as the falling i_busy.
  task automatic send_frame(input int n, input int base, input bit commit, input bit tail_eof);
    int tot;
    tot = n + FCS;
    bus.i_busy = 1'b1;
    tick();
    for (int i = 0; i < tot; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = (i < n) ? 8'(base + i) : 8'(8'hA0 + i);
      if (tail_eof && (i == tot - 1)) bus.i_busy = 1'b0;
      if (commit && (i < n)) exp_q.push_back({11'(n), (i == n - 1), 8'(base + i)});
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_busy  = 1'b0;
    if (!commit && exp_drop < 255) exp_drop++;
    tick();
    tick();
  endtask

  // Run the consumer until every expected beat has been taken (bounded)
  task automatic drain(input bit alt, input string tag);
    int cyc;
    cyc = 0;
    bus.i_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_frame_rdy) && cyc < 5000) begin
      tick();
      cyc++;
      if (alt) bus.i_ready = ~bus.i_ready;
    end
    chk({tag, "_timeout"}, 32'(cyc < 5000), 32'd1);
    bus.i_ready = 1'b1;
    tick();
    chk({tag, "_valid_low"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_last_low"},  32'(bus.o_last),  32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_o_data"},      32'(bus.o_data),      32'd0);
    chk({tag, "_o_valid"},     32'(bus.o_valid),     32'd0);
    chk({tag, "_o_last"},      32'(bus.o_last),      32'd0);
    chk({tag, "_o_len"},       32'(bus.o_len),       32'd0);
    chk({tag, "_o_frame_rdy"}, 32'(bus.o_frame_rdy), 32'd0);
    chk({tag, "_o_full"},      32'(bus.o_full),      32'd0);
    chk({tag, "_o_drop_cnt"},  32'(bus.o_drop_cnt),  32'd0);
  endtask

  initial begin
    // Reset
    bus.i_data  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_busy  = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_outputs_zero("post_reset");

    // 1: one 60-byte frame, consumer always ready
    send_frame(60, 8'h00, 1'b1, 1'b0);
    drain(1'b0, "t1");
    chk("t1_drop", 32'(bus.o_drop_cnt), 32'(exp_drop));

    // 2: 10-byte runt then a 60-byte frame whose last byte rides on eof
    send_frame(10, 8'h80, 1'b0, 1'b0);
    chk("t2_drop", 32'(bus.o_drop_cnt), 32'(exp_drop));
    send_frame(60, 8'h10, 1'b1, 1'b1);
    drain(1'b0, "t2");

    // 3: 64-byte frame drained with i_ready toggling every cycle
    bus.i_ready = 1'b0;
    send_frame(64, 8'h40, 1'b1, 1'b0);
    drain(1'b1, "t3");

    // 4: six 64-byte frames with consumer stalled. The first frame is popped
    //    straight into the streamer, so frames 2..5 fill the 4-deep queue and
    //    frame 6 finds it full and is dropped.
    bus.i_ready = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(64, 8'h20 * f, 1'b1, 1'b0);
    chk("t4_not_full_3q", 32'(bus.o_full), 32'd0);
    send_frame(64, 8'h90, 1'b1, 1'b0);
    chk("t4_full", 32'(bus.o_full), 32'd1);
    send_frame(64, 8'hC0, 1'b0, 1'b0);
    chk("t4_full_after_drop", 32'(bus.o_full), 32'd1);
    chk("t4_drop", 32'(bus.o_drop_cnt), 32'(exp_drop));
    drain(1'b0, "t4");
    chk("t4_full_clear", 32'(bus.o_full), 32'd0);

    // 5: oversize frame dropped; MAX_LEN frame and MIN_LEN frame committed
    send_frame(MAX_LEN + 1, 8'h05, 1'b0, 1'b0);
    chk("t5_drop", 32'(bus.o_drop_cnt), 32'(exp_drop));
    send_frame(MAX_LEN - FCS, 8'h33, 1'b1, 1'b0);
    drain(1'b0, "t5_max");
    send_frame(46, 8'h60, 1'b1, 1'b1);
    drain(1'b0, "t5_min");
    chk("t5_drop_after", 32'(bus.o_drop_cnt), 32'(exp_drop));

    // 6: reset while a frame is stalled on the output and another is 20 bytes in
    bus.i_ready = 1'b0;
    send_frame(60, 8'h70, 1'b1, 1'b0);
    tick();
    tick();
    chk("t6_valid_before_rst", 32'(bus.o_valid), 32'd1);
    bus.i_busy = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'(8'hE0 + i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_rst");
    exp_q.delete();
    exp_drop    = 0;
    bus.i_valid = 1'b0;
    bus.i_busy  = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_outputs_zero("t6_release");
    send_frame(60, 8'h3C, 1'b1, 1'b0);
    drain(1'b0, "t6");
    chk("t6_drop", 32'(bus.o_drop_cnt), 32'(exp_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
